// File: rtl/axi_sha_stream_out.sv
// -----------------------------------------------------------------------------
// axi_sha_stream_out
//
// AXI4-Stream output stage for the SHA-3 core. When a hash completes, this block
// captures the 1600-bit Keccak state. It then serialises either the digest or
// the full state as a packet of WIDTH-bit beats. The stream honours TREADY
// backpressure, flags the final beat with TLAST and qualifies a partial final
// word with TKEEP.
//
// Parameters
//   WIDTH      : TDATA width in bits (8, 16, 32 or 64).
//   MSB_FIRST  : 0 -> stream byte 0 in TDATA[7:0];
//                1 -> stream byte 0 in TDATA[WIDTH-1:WIDTH-8].
//
// Ports
//   ACLK           in   clock, rising edge
//   ARESET         in   synchronous active-high reset
//   state_i        in   Keccak state; digest byte k = state_i[8k+7:8k]
//   mode_i         in   0/1/2/3 = SHA3-224/256/384/512
//   full_i         in   1 = dump all 200 state bytes (overrides mode_i)
//   state_valid_i  in   state_i/mode_i/full_i valid
//   state_ready_o  out  block can accept a state
//   TDATA_o        out  stream data
//   TKEEP_o        out  byte-valid mask, bit i qualifies TDATA_o[8i+7:8i]
//   TUSER_o        out  mode_i as captured, held for the whole packet
//   TVALID_o       out  beat valid
//   TLAST_o        out  final beat of the packet
//   TREADY_i       in   downstream accepts the beat
// -----------------------------------------------------------------------------
module axi_sha_stream_out #(
   parameter int unsigned WIDTH     = 16,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic               ACLK,
   input  logic               ARESET,
   input  logic [1599:0]      state_i,
   input  logic [1:0]         mode_i,
   input  logic               full_i,
   input  logic               state_valid_i,
   output logic               state_ready_o,
   output logic [WIDTH-1:0]   TDATA_o,
   output logic [WIDTH/8-1:0] TKEEP_o,
   output logic [1:0]         TUSER_o,
   output logic               TVALID_o,
   output logic               TLAST_o,
   input  logic               TREADY_i
);

   localparam int unsigned WB = WIDTH / 8;                 // bytes per beat
   localparam int unsigned CW = $clog2(1600 / WIDTH);      // beat counter width

   typedef enum logic {
      ST_IDLE,
      ST_SEND
   } state_e;

   // Index of the last beat (N-1) for a packet of len_bytes bytes.
   function automatic logic [CW-1:0] last_idx_of(input int unsigned len_bytes);
      return CW'((len_bytes + WB - 1) / WB - 1);
   endfunction

   // TKEEP pattern for the last beat. R valid bytes sit in the lanes that
   // carry the earliest stream bytes: the low lanes when LSB-first, and the
   // high lanes when MSB-first.
   function automatic logic [WB-1:0] last_keep_of(input int unsigned len_bytes);
      int unsigned rem;
      logic [WB-1:0] keep;
      rem  = len_bytes - ((len_bytes + WB - 1) / WB - 1) * WB;
      keep = '0;
      for (int unsigned i = 0; i < WB; i++) begin
         if (i < rem) begin
            if (MSB_FIRST) begin
               keep[WB-1-i] = 1'b1;
            end else begin
               keep[i] = 1'b1;
            end
         end
      end
      return keep;
   endfunction

   // Packet geometry per length. Only the five legal lengths exist, so the
   // geometry is folded into constants and never divided at run time.
   localparam logic [CW-1:0] LI_224  = last_idx_of(28);
   localparam logic [CW-1:0] LI_256  = last_idx_of(32);
   localparam logic [CW-1:0] LI_384  = last_idx_of(48);
   localparam logic [CW-1:0] LI_512  = last_idx_of(64);
   localparam logic [CW-1:0] LI_FULL = last_idx_of(200);
   localparam logic [WB-1:0] LK_224  = last_keep_of(28);
   localparam logic [WB-1:0] LK_256  = last_keep_of(32);
   localparam logic [WB-1:0] LK_384  = last_keep_of(48);
   localparam logic [WB-1:0] LK_512  = last_keep_of(64);
   localparam logic [WB-1:0] LK_FULL = last_keep_of(200);

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_e          state_q,     state_d;
   logic [CW-1:0]   cnt_q,       cnt_d;        // index of the beat on TDATA_o
   logic [1:0]      tuser_q,     tuser_d;
   logic [1599:0]   shreg_q,     shreg_d;      // byte 0 of the current beat at [7:0]
   logic [CW-1:0]   last_idx_q,  last_idx_d;   // N-1, latched at load
   logic [WB-1:0]   last_keep_q, last_keep_d;  // TKEEP of the last beat, latched at load

   // ---------------------------------------------------------------------------
   // Load-time selection
   // ---------------------------------------------------------------------------
   logic [7:0]      len_sel;
   logic [CW-1:0]   last_idx_sel;
   logic [WB-1:0]   last_keep_sel;
   logic [1599:0]   load_data;
   logic            load;
   logic            handshake;

   // NOTE: every signal assigned in an always_comb gets a default first. If any
   // path left a signal unassigned, the tool would infer a latch.
   always_comb begin
      len_sel       = 8'd200;
      last_idx_sel  = LI_FULL;
      last_keep_sel = LK_FULL;
      if (!full_i) begin
         unique case (mode_i)
            2'd0: begin len_sel = 8'd28; last_idx_sel = LI_224; last_keep_sel = LK_224; end
            2'd1: begin len_sel = 8'd32; last_idx_sel = LI_256; last_keep_sel = LK_256; end
            2'd2: begin len_sel = 8'd48; last_idx_sel = LI_384; last_keep_sel = LK_384; end
            default: begin len_sel = 8'd64; last_idx_sel = LI_512; last_keep_sel = LK_512; end
         endcase
      end
   end

   // Only the first L bytes enter the shift register. Bytes above L are zero,
   // and the right shift also fills with zeros. As a result, the unused lanes
   // of the final beat always come out as 0.
   always_comb begin
      load_data = '0;
      for (int unsigned k = 0; k < 200; k++) begin
         if (8'(k) < len_sel) begin
            load_data[8*k +: 8] = state_i[8*k +: 8];
         end
      end
   end

   assign load      = (state_q == ST_IDLE) && state_valid_i;
   assign handshake = (state_q == ST_SEND) && TREADY_i;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. All flops then
   // sample pre-edge values, whatever order the blocks are evaluated in.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tuser_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tuser_q <= tuser_d;
      end
   end

   // NOTE: the wide shift register and the latched geometry are not reset.
   // The datapath reads them only in SEND, and SEND is always entered through
   // a load that overwrites them. A reset here would only add fan-out to
   // 1600+ flops.
   always_ff @(posedge ACLK) begin
      shreg_q     <= shreg_d;
      last_idx_q  <= last_idx_d;
      last_keep_q <= last_keep_d;
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and datapath update
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (state_valid_i)                      state_d = ST_SEND;
         ST_SEND: if (TREADY_i && (cnt_q == last_idx_q))  state_d = ST_IDLE;
         default:                                         state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      tuser_d     = tuser_q;
      last_idx_d  = last_idx_q;
      last_keep_d = last_keep_q;
      if (load) begin
         shreg_d     = load_data;
         cnt_d       = '0;
         tuser_d     = mode_i;
         last_idx_d  = last_idx_sel;
         last_keep_d = last_keep_sel;
      end else if (handshake) begin
         // Each accepted beat moves the next WB stream bytes to the bottom.
         shreg_d = shreg_q >> WIDTH;
         cnt_d   = cnt_q + CW'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Beat formatting: the bottom WB bytes of the shift register, placed into
   // lanes in stream order or in reversed order.
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] beat_raw;
   logic [WIDTH-1:0] lane_data;

   assign beat_raw = shreg_q[WIDTH-1:0];

   always_comb begin
      lane_data = '0;
      for (int unsigned b = 0; b < WB; b++) begin
         int unsigned lane;
         lane = MSB_FIRST ? (WB - 1 - b) : b;
         lane_data[8*lane +: 8] = beat_raw[8*b +: 8];
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs. These are derived from registered state only; TVALID_o never
   // looks at TREADY_i.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_ready_o = (state_q == ST_IDLE);
      TVALID_o      = 1'b0;
      TLAST_o       = 1'b0;
      TKEEP_o       = '0;
      TDATA_o       = '0;
      TUSER_o       = tuser_q;
      if (state_q == ST_SEND) begin
         TVALID_o = 1'b1;
         TLAST_o  = (cnt_q == last_idx_q);
         TKEEP_o  = (cnt_q == last_idx_q) ? last_keep_q : '1;
         TDATA_o  = lane_data;
      end
   end

endmodule
